// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter sequencer.
package pc_pkg;

    localparam int PC_DEFAULT_XLEN = 32;
    localparam int PC_MAX_XLEN     = 64;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_TRAP,
        SEL_TARGET,
        SEL_RAS,
        SEL_HOLD,
        SEL_SEQ
    } next_pc_sel_t;

    // Clears the low 'align' bits of an address; callers truncate back to XLEN.
    function automatic logic [PC_MAX_XLEN-1:0] align_addr(
        input logic [PC_MAX_XLEN-1:0] addr,
        input int unsigned            align
    );
        logic [PC_MAX_XLEN-1:0] mask;
        mask = ~((PC_MAX_XLEN'(1) << align) - PC_MAX_XLEN'(1));
        return addr & mask;
    endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return address stack: overwrites the oldest entry when full, ignores pops when empty.
module return_address_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [XLEN-1:0] pushData,
    input  logic            pop,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_sp;
    logic [PW:0]     r_count;
    logic            w_do_pop;
    logic [PW-1:0]   w_sp_dec;

    assign w_sp_dec = r_sp - PW'(1);
    assign w_do_pop = pop && (r_count != '0);
    assign top      = r_mem[w_sp_dec];
    assign empty    = (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp    <= '0;
            r_count <= '0;
        end else begin
            case ({push, w_do_pop})
                2'b10: begin
                    r_sp <= r_sp + PW'(1);
                    if (r_count != (PW+1)'(DEPTH)) begin
                        r_count <= r_count + (PW+1)'(1);
                    end
                end
                2'b01: begin
                    r_sp    <= w_sp_dec;
                    r_count <= r_count - (PW+1)'(1);
                end
                default: ;
            endcase
        end
    end

    // Storage is not reset; simultaneous pop+push replaces the top in place.
    always_ff @(posedge clk) begin
        if (push) begin
            if (w_do_pop) begin
                r_mem[w_sp_dec] <= pushData;
            end else begin
                r_mem[r_sp] <= pushData;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with trap/branch/return redirect priority and alignment check.
// Optional return address stack prediction is enabled by defining PC_RAS_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = PC_DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            isStalled,
    input  logic            trapTaken,
    input  logic [XLEN-1:0] trapVector,
    input  logic            shouldGoToTarget,
    input  logic [XLEN-1:0] jumpTarget,
    input  logic            isCall,
    input  logic            isReturn,
    output logic [XLEN-1:0] pc,
    output logic            pcValid,
    output logic            redirected,
    output logic            misalignedTarget,
    output logic            rasEmpty
);
    localparam int unsigned     ALIGN = $clog2(INSTR_BYTES);
    localparam logic [XLEN-1:0] STEP  = XLEN'(INSTR_BYTES);

    next_pc_sel_t    w_sel;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_trap_al;
    logic [XLEN-1:0] w_target_al;
    logic [XLEN-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_trap_mis;
    logic            w_target_mis;

    assign w_seq_pc     = pc + STEP;
    assign w_trap_al    = XLEN'(align_addr(PC_MAX_XLEN'(trapVector), ALIGN));
    assign w_target_al  = XLEN'(align_addr(PC_MAX_XLEN'(jumpTarget), ALIGN));
    assign w_trap_mis   = |trapVector[ALIGN-1:0];
    assign w_target_mis = |jumpTarget[ALIGN-1:0];
    assign rasEmpty     = w_ras_empty;

`ifdef PC_RAS_EN
    logic w_ras_push;
    logic w_ras_pop;

    // Push/pop track the instruction stream even when a trap or branch wins the mux.
    assign w_ras_push = isCall && !isStalled && !rst;
    assign w_ras_pop  = isReturn && !isStalled && !rst;

    return_address_stack #(
        .XLEN (XLEN),
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (w_ras_push),
        .pushData(w_seq_pc),
        .pop     (w_ras_pop),
        .top     (w_ras_top),
        .empty   (w_ras_empty)
    );
`else
    logic w_unused_ras;
    assign w_unused_ras = ^{isCall, isReturn};
    assign w_ras_top    = '0;
    assign w_ras_empty  = 1'b1;
`endif

    always_comb begin
        w_sel = SEL_SEQ;
        if (rst) begin
            w_sel = SEL_RESET;
        end else if (trapTaken) begin
            w_sel = SEL_TRAP;
        end else if (shouldGoToTarget) begin
            w_sel = SEL_TARGET;
`ifdef PC_RAS_EN
        end else if (isReturn && !w_ras_empty && !isStalled) begin
            w_sel = SEL_RAS;
`endif
        end else if (isStalled) begin
            w_sel = SEL_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        case (w_sel)
            SEL_RESET:  pc <= RESET_VECTOR;
            SEL_TRAP:   pc <= w_trap_al;
            SEL_TARGET: pc <= w_target_al;
            SEL_RAS:    pc <= w_ras_top;
            SEL_HOLD:   pc <= pc;
            default:    pc <= w_seq_pc;
        endcase
        pcValid          <= !rst;
        redirected       <= (w_sel == SEL_TRAP) || (w_sel == SEL_TARGET) || (w_sel == SEL_RAS);
        misalignedTarget <= ((w_sel == SEL_TRAP) && w_trap_mis) ||
                            ((w_sel == SEL_TARGET) && w_target_mis);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; RAS scenarios run when PC_RAS_EN is defined.
module tb_pc_sequencer;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            isStalled;
    logic            trapTaken;
    logic [XLEN-1:0] trapVector;
    logic            shouldGoToTarget;
    logic [XLEN-1:0] jumpTarget;
    logic            isCall;
    logic            isReturn;
    logic [XLEN-1:0] pc;
    logic            pcValid;
    logic            redirected;
    logic            misalignedTarget;
    logic            rasEmpty;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(
        .XLEN        (XLEN),
        .RESET_VECTOR(32'h100),
        .INSTR_BYTES (4),
        .RAS_DEPTH   (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .isStalled       (isStalled),
        .trapTaken       (trapTaken),
        .trapVector      (trapVector),
        .shouldGoToTarget(shouldGoToTarget),
        .jumpTarget      (jumpTarget),
        .isCall          (isCall),
        .isReturn        (isReturn),
        .pc              (pc),
        .pcValid         (pcValid),
        .redirected      (redirected),
        .misalignedTarget(misalignedTarget),
        .rasEmpty        (rasEmpty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        isStalled        = 1'b0;
        trapTaken        = 1'b0;
        trapVector       = '0;
        shouldGoToTarget = 1'b0;
        jumpTarget       = '0;
        isCall           = 1'b0;
        isReturn         = 1'b0;
    endtask

    task automatic jump_to(input logic [XLEN-1:0] a);
        shouldGoToTarget = 1'b1;
        jumpTarget       = a;
        step();
        shouldGoToTarget = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;

        // T1 reset and release
        step();
        step();
        chk("rst_pc", 64'(pc), 64'h100);
        chk("rst_valid", 64'(pcValid), 64'd0);
        chk("rst_redir", 64'(redirected), 64'd0);
        chk("rst_mis", 64'(misalignedTarget), 64'd0);
        chk("rst_rasempty", 64'(rasEmpty), 64'd1);
        rst = 1'b0;
        step();
        chk("rel_pc0", 64'(pc), 64'h104);
        chk("rel_valid", 64'(pcValid), 64'd1);
        step();
        chk("rel_pc1", 64'(pc), 64'h108);
        chk("rel_redir", 64'(redirected), 64'd0);

        // T2 stall versus redirect
        jump_to(32'h20);
        chk("t2_pc20", 64'(pc), 64'h20);
        chk("t2_redir20", 64'(redirected), 64'd1);
        isStalled = 1'b1;
        step();
        chk("t2_hold0", 64'(pc), 64'h20);
        chk("t2_hold_redir", 64'(redirected), 64'd0);
        step();
        chk("t2_hold1", 64'(pc), 64'h20);
        shouldGoToTarget = 1'b1;
        jumpTarget       = 32'h80;
        step();
        chk("t2_stall_tgt", 64'(pc), 64'h80);
        chk("t2_stall_redir", 64'(redirected), 64'd1);
        clear_inputs();

        // T3 trap beats target and stall
        trapTaken        = 1'b1;
        trapVector       = 32'h4000;
        shouldGoToTarget = 1'b1;
        jumpTarget       = 32'h80;
        isStalled        = 1'b1;
        step();
        chk("t3_trap_pc", 64'(pc), 64'h4000);
        chk("t3_trap_redir", 64'(redirected), 64'd1);
        clear_inputs();
        step();
        chk("t3_seq_pc", 64'(pc), 64'h4004);
        chk("t3_seq_redir", 64'(redirected), 64'd0);

        // T4 misaligned targets and wrap
        jump_to(32'h83);
        chk("t4_mis_pc", 64'(pc), 64'h80);
        chk("t4_mis_flag", 64'(misalignedTarget), 64'd1);
        step();
        chk("t4_mis_pc1", 64'(pc), 64'h84);
        chk("t4_mis_clear", 64'(misalignedTarget), 64'd0);
        trapTaken  = 1'b1;
        trapVector = 32'h4002;
        step();
        trapTaken = 1'b0;
        chk("t4_trap_mis_pc", 64'(pc), 64'h4000);
        chk("t4_trap_mis_flag", 64'(misalignedTarget), 64'd1);
        jump_to(32'hFFFF_FFFC);
        chk("t4_top_pc", 64'(pc), 64'hFFFF_FFFC);
        chk("t4_top_mis", 64'(misalignedTarget), 64'd0);
        step();
        chk("t4_wrap_pc", 64'(pc), 64'h0);
        chk("t4_wrap_mis", 64'(misalignedTarget), 64'd0);
        chk("t4_wrap_redir", 64'(redirected), 64'd0);

`ifndef PC_RAS_EN
        // Without RAS, call/return hints are ignored
        isCall   = 1'b1;
        isReturn = 1'b1;
        step();
        chk("noras_pc", 64'(pc), 64'h4);
        chk("noras_redir", 64'(redirected), 64'd0);
        chk("noras_empty", 64'(rasEmpty), 64'd1);
        clear_inputs();
`endif

        // Reset mid-run wins over trap
        rst        = 1'b1;
        trapTaken  = 1'b1;
        trapVector = 32'h4000;
        step();
        chk("mid_rst_pc", 64'(pc), 64'h100);
        chk("mid_rst_valid", 64'(pcValid), 64'd0);
        clear_inputs();
        rst = 1'b0;

`ifdef PC_RAS_EN
        // T5 single call/return
        jump_to(32'h10);
        isCall = 1'b1;
        step();
        isCall = 1'b0;
        chk("t5_call_pc", 64'(pc), 64'h14);
        chk("t5_nonempty", 64'(rasEmpty), 64'd0);
        jump_to(32'h200);
        isReturn = 1'b1;
        isStalled = 1'b1;
        step();
        chk("t5_stall_ret", 64'(pc), 64'h200);
        isStalled = 1'b0;
        step();
        chk("t5_ret_pc", 64'(pc), 64'h14);
        chk("t5_ret_redir", 64'(redirected), 64'd1);
        chk("t5_ret_empty", 64'(rasEmpty), 64'd1);
        step();
        chk("t5_ret2_pc", 64'(pc), 64'h18);
        chk("t5_ret2_redir", 64'(redirected), 64'd0);
        isReturn = 1'b0;

        // T6 overflow with depth 4
        for (int i = 0; i < 5; i++) begin
            jump_to(32'(i * 16));
            isCall = 1'b1;
            step();
            isCall = 1'b0;
        end
        chk("t6_nonempty", 64'(rasEmpty), 64'd0);
        jump_to(32'h300);
        isReturn = 1'b1;
        step();
        chk("t6_ret0", 64'(pc), 64'h44);
        step();
        chk("t6_ret1", 64'(pc), 64'h34);
        step();
        chk("t6_ret2", 64'(pc), 64'h24);
        step();
        chk("t6_ret3", 64'(pc), 64'h14);
        chk("t6_empty", 64'(rasEmpty), 64'd1);
        step();
        chk("t6_ret4_pc", 64'(pc), 64'h18);
        chk("t6_ret4_redir", 64'(redirected), 64'd0);
        isReturn = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
